// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch sequencer
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_HOLD    = 2'd2,
        ST_DISCARD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - one-entry {pc, instr} holding buffer for a stalled decode stage
module fetch_skid_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_instr,
    output logic        full,
    output logic [31:0] buf_pc,
    output logic [31:0] buf_instr
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full      <= 1'b0;
            buf_pc    <= 32'd0;
            buf_instr <= 32'd0;
        end else if (clear) begin
            full      <= 1'b0;
            buf_pc    <= 32'd0;
            buf_instr <= 32'd0;
        end else if (load) begin
            full      <= 1'b1;
            buf_pc    <= in_pc;
            buf_instr <= in_instr;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - one-outstanding instruction fetch sequencer feeding the IF/ID register
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        hazard_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_instr,
    output logic        ifid_valid,
    output logic        ifid_stall
);

    localparam logic [1:0] S_IDLE    = ST_IDLE;
    localparam logic [1:0] S_FETCH   = ST_FETCH;
    localparam logic [1:0] S_HOLD    = ST_HOLD;
    localparam logic [1:0] S_DISCARD = ST_DISCARD;

    logic [1:0]  state;
    logic [31:0] fetch_addr_q;
    logic [31:0] target_q;
    logic        buf_full;
    logic [31:0] buf_pc;
    logic [31:0] buf_instr;

    logic in_fetch, in_hold, in_discard;
    logic pass_valid, hold_valid, buf_load, buf_clear;

    assign in_fetch   = (state == S_FETCH);
    assign in_hold    = (state == S_HOLD);
    assign in_discard = (state == S_DISCARD);

    // A redirect always wins: it kills both the pass-through word and the buffered one.
    assign pass_valid = in_fetch & imem_rvalid & !redirect_valid & !hazard_stall;
    assign hold_valid = in_hold & buf_full & !redirect_valid & !hazard_stall;
    assign buf_load   = in_fetch & imem_rvalid & !redirect_valid & hazard_stall;
    assign buf_clear  = in_hold & (redirect_valid | !hazard_stall);

    assign imem_req   = in_fetch | in_discard;
    assign imem_addr  = imem_req ? fetch_addr_q : 32'd0;
    assign ifid_valid = pass_valid | hold_valid;
    assign ifid_pc    = pass_valid ? fetch_addr_q : (hold_valid ? buf_pc : 32'd0);
    assign ifid_instr = pass_valid ? imem_rdata : (hold_valid ? buf_instr : 32'd0);
    assign ifid_stall = hazard_stall & !redirect_valid;

    fetch_skid_buf u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (buf_load),
        .clear     (buf_clear),
        .in_pc     (fetch_addr_q),
        .in_instr  (imem_rdata),
        .full      (buf_full),
        .buf_pc    (buf_pc),
        .buf_instr (buf_instr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            fetch_addr_q <= RESET_PC;
            target_q     <= 32'd0;
        end else begin
            case (state)
                S_IDLE: state <= S_FETCH;
                S_FETCH: begin
                    if (imem_rvalid) begin
                        if (redirect_valid) begin
                            fetch_addr_q <= redirect_pc;
                        end else begin
                            fetch_addr_q <= next_pc(fetch_addr_q);
                            if (hazard_stall) state <= S_HOLD;
                        end
                    end else if (redirect_valid) begin
                        // The in-flight read must still complete before the target can be issued.
                        target_q <= redirect_pc;
                        state    <= S_DISCARD;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid) begin
                        fetch_addr_q <= redirect_pc;
                        state        <= S_FETCH;
                    end else if (!hazard_stall) begin
                        state <= S_FETCH;
                    end
                end
                S_DISCARD: begin
                    if (imem_rvalid) begin
                        fetch_addr_q <= redirect_valid ? redirect_pc : target_q;
                        state        <= S_FETCH;
                    end else if (redirect_valid) begin
                        target_q <= redirect_pc;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - table-driven scoreboard bench for fetch_ctrl
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        hazard_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic        ifid_stall;

    fetch_ctrl #(.RESET_PC(32'h0000_0100)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .hazard_stall   (hazard_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ifid_pc        (ifid_pc),
        .ifid_instr     (ifid_instr),
        .ifid_valid     (ifid_valid),
        .ifid_stall     (ifid_stall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        stall;
    } out_t;

    typedef struct {
        logic        rv;
        logic [31:0] rdata;
        logic        hz;
        logic        rd;
        logic [31:0] rpc;
        out_t        exp;
    } vec_t;

    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    vec_t tbl[$];
    vec_t post[$];
    out_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [31:0] ins(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    function automatic vec_t mk(input logic rv, input logic [31:0] rdata, input logic hz,
                                input logic rd, input logic [31:0] rpc,
                                input logic req, input logic [31:0] addr, input logic valid,
                                input logic [31:0] pc, input logic stall);
        vec_t v;
        v.rv = rv; v.rdata = rdata; v.hz = hz; v.rd = rd; v.rpc = rpc;
        v.exp.req   = req;
        v.exp.addr  = addr;
        v.exp.valid = valid;
        v.exp.pc    = valid ? pc : 32'd0;
        v.exp.instr = valid ? rdata : 32'd0;
        v.exp.stall = stall;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        imem_rvalid    = v.rv;
        imem_rdata     = v.rdata;
        hazard_stall   = v.hz;
        redirect_valid = v.rd;
        redirect_pc    = v.rpc;
        exp_q.push_back(v.exp);
    endtask

    task automatic check(input string name);
        out_t a, e;
        a = {imem_req, imem_addr, ifid_valid, ifid_pc, ifid_instr, ifid_stall};
        n_vec++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: scoreboard empty, got req=%b addr=%h valid=%b", name, a.req, a.addr, a.valid);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                n_bad++;
                $display("FAIL %s: got req=%b addr=%h valid=%b pc=%h instr=%h stall=%b, expected req=%b addr=%h valid=%b pc=%h instr=%h stall=%b",
                         name, a.req, a.addr, a.valid, a.pc, a.instr, a.stall,
                         e.req, e.addr, e.valid, e.pc, e.instr, e.stall);
            end
        end
    endtask

    task automatic run(input vec_t v, input string name);
        drive(v);
        #1;
        check(name);
        @(negedge clk);
    endtask

    initial begin
        //           rv  rdata                  hz  rd  rpc            req addr           vld pc             stall
        tbl.push_back(mk(0, JUNK,               0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0)); // IDLE
        tbl.push_back(mk(1, ins(32'h100),       0, 0, 32'h0,          1, 32'h100,        1, 32'h100,        0));
        tbl.push_back(mk(1, ins(32'h104),       1, 0, 32'h0,          1, 32'h104,        0, 32'h0,          1)); // -> HOLD
        tbl.push_back(mk(0, JUNK,               1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          1));
        tbl.push_back(mk(0, JUNK,               1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          1));
        tbl.push_back(mk(0, ins(32'h104),       0, 0, 32'h0,          0, 32'h0,          1, 32'h104,        0)); // buffer out
        tbl.push_back(mk(0, JUNK,               0, 0, 32'h0,          1, 32'h108,        0, 32'h0,          0));
        tbl.push_back(mk(0, JUNK,               0, 1, 32'h200,        1, 32'h108,        0, 32'h0,          0)); // -> DISCARD
        tbl.push_back(mk(0, JUNK,               0, 0, 32'h0,          1, 32'h108,        0, 32'h0,          0));
        tbl.push_back(mk(1, ins(32'h108),       0, 0, 32'h0,          1, 32'h108,        0, 32'h0,          0)); // dropped
        tbl.push_back(mk(0, JUNK,               0, 1, 32'h250,        1, 32'h200,        0, 32'h0,          0)); // -> DISCARD
        tbl.push_back(mk(0, JUNK,               0, 1, 32'h300,        1, 32'h200,        0, 32'h0,          0));
        tbl.push_back(mk(0, JUNK,               0, 1, 32'h400,        1, 32'h200,        0, 32'h0,          0));
        tbl.push_back(mk(1, ins(32'h200),       0, 0, 32'h0,          1, 32'h200,        0, 32'h0,          0));
        tbl.push_back(mk(1, ins(32'h400),       0, 0, 32'h0,          1, 32'h400,        1, 32'h400,        0));
        tbl.push_back(mk(1, ins(32'h404),       1, 0, 32'h0,          1, 32'h404,        0, 32'h0,          1)); // -> HOLD
        tbl.push_back(mk(0, JUNK,               1, 1, 32'h500,        0, 32'h0,          0, 32'h0,          0)); // flush beats stall
        tbl.push_back(mk(1, ins(32'h500),       0, 0, 32'h0,          1, 32'h500,        1, 32'h500,        0));
        tbl.push_back(mk(1, ins(32'h504),       0, 1, 32'hFFFF_FFFC,  1, 32'h504,        0, 32'h0,          0));
        tbl.push_back(mk(1, ins(32'hFFFF_FFFC), 0, 0, 32'h0,          1, 32'hFFFF_FFFC,  1, 32'hFFFF_FFFC,  0));
        tbl.push_back(mk(1, ins(32'h0),         1, 1, 32'h600,        1, 32'h0,          0, 32'h0,          0)); // wrapped
        tbl.push_back(mk(0, JUNK,               0, 0, 32'h0,          1, 32'h600,        0, 32'h0,          0));
        tbl.push_back(mk(0, JUNK,               0, 1, 32'h700,        1, 32'h600,        0, 32'h0,          0)); // -> DISCARD
        tbl.push_back(mk(1, ins(32'h600),       0, 1, 32'h800,        1, 32'h600,        0, 32'h0,          0)); // late redirect wins
        tbl.push_back(mk(0, JUNK,               0, 0, 32'h0,          1, 32'h800,        0, 32'h0,          0));

        post.push_back(mk(1, ins(32'h800),      0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0)); // late rvalid in IDLE
        post.push_back(mk(1, ins(32'h100),      0, 0, 32'h0,          1, 32'h100,        1, 32'h100,        0));
        post.push_back(mk(1, ins(32'h104),      0, 0, 32'h0,          1, 32'h104,        1, 32'h104,        0));

        rst = 1'b0;
        drive(mk(0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0));
        @(negedge clk);
        check("reset_state");
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < tbl.size(); i++) run(tbl[i], $sformatf("vec%0d", i));

        drive(mk(0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0));
        #1 rst = 1'b0;
        #1 check("reset_mid_request");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < post.size(); i++) run(post[i], $sformatf("post%0d", i));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
